vga_read_timing_gen: RTL and testbench
======================================

Name: vga_read_timing_gen

Overview:
- Generates the display-side timing that drives the grayscale line-buffer readout path: VGA_HS, VGA_VS, READ_Request, plus active-pixel column and row indices.
- It is the initiator for the read side. Downstream read counters and line buffers consume READ_Request and VGA_VS, sample pixels while READ_Request is high, and restart on VGA_VS.
- Default timing is 640x480 at 60 Hz from a 25 MHz VGA_CLK.

Parameters:
- H_SYNC, 96, horizontal sync width in clocks
- H_BP, 48, horizontal back porch in clocks
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch in clocks
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- V_ACT, 480, active lines per frame
- V_FP, 10, vertical front porch in lines

Ports:
- VGA_CLK  in  1  pixel clock; the only clock
- RST  in  1  reset, synchronous, active-high
- iENABLE  in  1  run/freeze control
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- READ_Request  out  1  high for each active pixel
- oX  out  11  active column 0..H_ACT-1; 0 outside the active region
- oY  out  11  active row 0..V_ACT-1; 0 outside active lines
- oFrame_Start  out  1  one-clock pulse at the first active pixel of each frame
- oDATA  out  10  test-pattern pixel (see Optional Feature)

Behaviour:
- Derived totals: H_TOT = H_SYNC+H_BP+H_ACT+H_FP (800); V_TOT = V_SYNC+V_BP+V_ACT+V_FP (525).
- Counters:
  - h_cnt counts 0..H_TOT-1 and wraps to 0.
  - v_cnt increments only when h_cnt wraps; it counts 0..V_TOT-1 and wraps to 0.
  - Both counters are 11 bits.
- Region order within each line and frame: sync, back porch, active, front porch.
  - Horizontal active: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1], i.e. [144, 783].
  - Vertical active: v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1], i.e. [35, 514].
- Every output is a registered decode of the counters. Outputs therefore lag the counter value by one clock, and all outputs are mutually aligned.
- Decode rules:
  - VGA_HS = 0 iff h_cnt < H_SYNC.
  - VGA_VS = 0 iff v_cnt < V_SYNC, across the whole line including porches.
  - READ_Request = 1 iff h_cnt is horizontally active AND v_cnt is vertically active.
  - oX = h_cnt-(H_SYNC+H_BP) while READ_Request is high, else 0.
  - oY = v_cnt-(V_SYNC+V_BP) while v_cnt is vertically active, else 0.
  - oFrame_Start = 1 only with READ_Request=1, oX=0, oY=0.
- Reset, when RST is high at a clock edge:
  - h_cnt=0, v_cnt=0.
  - VGA_HS=1, VGA_VS=1, READ_Request=0, oX=0, oY=0, oFrame_Start=0, oDATA=0.
  - RST overrides iENABLE.
  - A reset asserted mid-frame aborts the frame. There is no partial-line completion.
- First edge after RST drops (with iENABLE=1): outputs show counter state 0, so VGA_HS=0 and VGA_VS=0.
- iENABLE=0:
  - Counters hold.
  - READ_Request and oFrame_Start are forced 0 on the next edge.
  - VGA_HS, VGA_VS, oX and oY hold their last values.
- iENABLE=1 again: outputs resume from the held counters on the next edge. The line is not restarted.
- Simultaneous wrap: at h_cnt=H_TOT-1 and v_cnt=V_TOT-1, both counters return to 0 on the same edge.
- Parameter constraints: all sync widths ≥ 1. H_TOT and V_TOT ≤ 2047.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN
- Defined:
  - oDATA = (oX + oY) mod 1024 while READ_Request=1, else 0.
  - oDATA is registered and aligned with READ_Request.
  - This diagonal ramp exercises the line buffer and the gray RGB path without a camera attached.
- Undefined: oDATA is tied to 0 and no adder is built.

Test Plan:
- Reset held 3 clocks, then released with iENABLE=1 -> during reset all outputs are at reset values. First post-reset edge: VGA_HS=0 and VGA_VS=0. VGA_HS stays low exactly 96 clocks, then is high for 704 clocks. Period is 800.
- Free-run one frame -> VGA_VS low for exactly 1600 clocks. READ_Request is high 640 consecutive clocks per active line, on 480 lines. Total READ_Request-high count is 307200. Frame period is 420000 clocks.
- First active pixel -> READ_Request rises 144 clocks after the HS falling edge of line 35. At that edge oX=0, oY=0 and oFrame_Start=1 for exactly one clock. The last active pixel shows oX=639, oY=479.
- iENABLE low for 50 clocks at oX=100 -> READ_Request=0 for those 50 clocks. On re-enable, oX resumes at 101 with no skipped or duplicated column.
- RST pulsed 1 clock at oY=200 -> next output shows reset values. The following edge restarts at counter 0, with VGA_VS low again.
- With VGA_TIMING_TEST_PATTERN_EN: pixel oX=639, oY=479 -> oDATA=94 (1118 mod 1024). Blanking -> oDATA=0. Without the macro, oDATA=0 always.

Source files
------------

// File: rtl/vga_read_timing_gen_if.sv
// Read-side VGA timing bundle: run control in, sync/request/pixel-index outputs.
interface vga_read_timing_gen_if;
  logic        iENABLE;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        READ_Request;
  logic [10:0] oX;
  logic [10:0] oY;
  logic        oFrame_Start;
  logic [9:0]  oDATA;

  modport master (
    input  iENABLE,
    output VGA_HS, VGA_VS, READ_Request, oX, oY, oFrame_Start, oDATA
  );

  modport slave (
    output iENABLE,
    input  VGA_HS, VGA_VS, READ_Request, oX, oY, oFrame_Start, oDATA
  );
endinterface

// File: rtl/vga_read_timing_gen.sv
// VGA read-side timing: registered decode of h/v counters, one clock behind the counters.
// Optional diagonal test pattern on oDATA when VGA_TIMING_TEST_PATTERN_EN is defined.
module vga_read_timing_gen #(
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10
) (
  input  logic                  VGA_CLK,
  input  logic                  RST,
  vga_read_timing_gen_if.master vga
);

  localparam logic [10:0] H_SYNC_C    = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [10:0] H_LAST      = 11'(H_SYNC + H_BP + H_ACT + H_FP - 1);
  localparam logic [10:0] V_SYNC_C    = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_START = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [10:0] V_LAST      = 11'(V_SYNC + V_BP + V_ACT + V_FP - 1);

  logic [10:0] hCnt, vCnt;
  logic [10:0] hCntNext, vCntNext;
  logic [10:0] xNext, yNext;
  logic        hActive, vActive, pixActive;
  logic        hsNext, vsNext, frameStartNext;

  always_comb begin
    hActive        = (hCnt >= H_ACT_START) && (hCnt <= H_ACT_END);
    vActive        = (vCnt >= V_ACT_START) && (vCnt <= V_ACT_END);
    pixActive      = hActive && vActive;
    hsNext         = (hCnt >= H_SYNC_C);
    vsNext         = (vCnt >= V_SYNC_C);
    xNext          = pixActive ? (hCnt - H_ACT_START) : 11'd0;
    yNext          = vActive ? (vCnt - V_ACT_START) : 11'd0;
    frameStartNext = pixActive && (hCnt == H_ACT_START) && (vCnt == V_ACT_START);

    // v advances only on the h wrap; both wrap together at the frame's last clock
    hCntNext = hCnt + 11'd1;
    vCntNext = vCnt;
    if (hCnt == H_LAST) begin
      hCntNext = 11'd0;
      vCntNext = (vCnt == V_LAST) ? 11'd0 : vCnt + 11'd1;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      hCnt             <= 11'd0;
      vCnt             <= 11'd0;
      vga.VGA_HS       <= 1'b1;
      vga.VGA_VS       <= 1'b1;
      vga.READ_Request <= 1'b0;
      vga.oX           <= 11'd0;
      vga.oY           <= 11'd0;
      vga.oFrame_Start <= 1'b0;
    end else if (vga.iENABLE) begin
      hCnt             <= hCntNext;
      vCnt             <= vCntNext;
      vga.VGA_HS       <= hsNext;
      vga.VGA_VS       <= vsNext;
      vga.READ_Request <= pixActive;
      vga.oX           <= xNext;
      vga.oY           <= yNext;
      vga.oFrame_Start <= frameStartNext;
    end else begin
      // frozen: syncs and indices hold, but no pixel may be requested
      vga.READ_Request <= 1'b0;
      vga.oFrame_Start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [10:0] rampSum;

  always_comb begin
    rampSum = xNext + yNext;
  end

  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      vga.oDATA <= 10'd0;
    end else if (vga.iENABLE && pixActive) begin
      vga.oDATA <= rampSum[9:0];
    end else begin
      vga.oDATA <= 10'd0;
    end
  end
`else
  assign vga.oDATA = 10'd0;
`endif

endmodule

// File: tb/tb_vga_read_timing_gen.sv
// Randomised enable/reset stimulus on a shrunken raster, checked against a linear-position model.
module tb_vga_read_timing_gen;

  localparam int HS = 4, HB = 3, HA = 10, HF = 2;
  localparam int VS = 2, VB = 2, VA = 5,  VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;

  logic VGA_CLK = 1'b0;
  logic RST     = 1'b1;

  vga_read_timing_gen_if vga ();

  vga_read_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF)
  ) dut (
    .VGA_CLK(VGA_CLK),
    .RST    (RST),
    .vga    (vga.master)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int nCompared = 0;
  int nMismatched = 0;

  // model: position within the frame as a single linear pixel-clock index
  int pos = 0;
  int eHs, eVs, eRr, eX, eY, eFs, eData;

  task automatic chk(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelEdge(input bit rst, input bit en);
    int h, v;
    bit hAct, vAct;
    if (rst) begin
      pos = 0;
      eHs = 1; eVs = 1; eRr = 0; eX = 0; eY = 0; eFs = 0; eData = 0;
    end else if (en) begin
      h    = pos % HT;
      v    = pos / HT;
      hAct = (h >= HS + HB) && (h < HS + HB + HA);
      vAct = (v >= VS + VB) && (v < VS + VB + VA);
      eHs  = (h < HS) ? 0 : 1;
      eVs  = (v < VS) ? 0 : 1;
      eRr  = (hAct && vAct) ? 1 : 0;
      eX   = eRr ? h - (HS + HB) : 0;
      eY   = vAct ? v - (VS + VB) : 0;
      eFs  = (eRr && eX == 0 && eY == 0) ? 1 : 0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      eData = eRr ? (eX + eY) % 1024 : 0;
`else
      eData = 0;
`endif
      pos = (pos + 1) % FRAME;
    end else begin
      eRr = 0; eFs = 0; eData = 0;
    end
  endtask

  task automatic step(input bit rst, input bit en);
    RST         = rst;
    vga.iENABLE = en;
    @(posedge VGA_CLK);
    modelEdge(rst, en);
    #1;
    chk("VGA_HS",       32'(vga.VGA_HS),       eHs);
    chk("VGA_VS",       32'(vga.VGA_VS),       eVs);
    chk("READ_Request", 32'(vga.READ_Request), eRr);
    chk("oX",           32'(vga.oX),           eX);
    chk("oY",           32'(vga.oY),           eY);
    chk("oFrame_Start", 32'(vga.oFrame_Start), eFs);
    chk("oDATA",        32'(vga.oDATA),        eData);
  endtask

  initial begin
    int rrCnt, vsLow, fsCnt, hsLowLine0, runLen, maxRun, lastX;
    bit en, rst;

    vga.iENABLE = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // one free-running frame with aggregate raster checks
    rrCnt = 0; vsLow = 0; fsCnt = 0; hsLowLine0 = 0; runLen = 0; maxRun = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1);
      if (vga.READ_Request) begin
        rrCnt++;
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        runLen = 0;
      end
      if (!vga.VGA_VS) vsLow++;
      if (vga.oFrame_Start) fsCnt++;
      if (i < HT && !vga.VGA_HS) hsLowLine0++;
    end
    chk("rr_total",    rrCnt,      HA * VA);
    chk("rr_run",      maxRun,     HA);
    chk("vs_low",      vsLow,      VS * HT);
    chk("fs_count",    fsCnt,      1);
    chk("hs_low_line", hsLowLine0, HS);

    // freeze mid-line, then confirm the column continues without a skip
    while (!(vga.READ_Request && vga.oX == 11'd3)) step(1'b0, 1'b1);
    lastX = int'(vga.oX);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("resume_x", 32'(vga.oX), lastX + 1);

    // randomised run/freeze and occasional mid-frame reset
    for (int i = 0; i < 4000; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step(rst, en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1 (bench did not complete)");
    $fatal(1, "timeout");
  end

endmodule
